// File: rtl/nibble_serial_subtractor_if.sv
// Handshake and data bundle for the nibble-serial subtractor.
// The requester (master) drives start and the operands; the subtractor
// (slave) returns the status, the difference and the condition flags.
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow_out, zero, neg, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow_out, zero, neg, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b for the miniRISC ALU path.
// One 4-bit nibble is subtracted per clock (LSB nibble first) as
// a + ~b + ~borrow using a generate/propagate lookahead; the borrow is
// registered between nibbles. Flags are produced when the last nibble lands.
module nibble_serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_subtractor_if.slave   bus
);

  localparam int NNIB = WIDTH / 4;
  localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  nibIdx_q;
  logic             borrowChain_q;
  logic [WIDTH-1:0] diff_q;
  logic             busy_q;
  logic             done_q;
  logic             borrowOut_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  logic [3:0]       nibA;
  logic [3:0]       nibB;
  logic             carryIn;
  logic [3:0]       gen;
  logic [3:0]       prop;
  logic [3:0]       carry;
  logic             carryOut;
  logic [3:0]       nibSum;
  logic             borrowChain_d;
  logic [WIDTH-1:0] diff_d;

  // Current nibble: a + ~b + ~borrow with all carries looked ahead from g/p,
  // and the full difference as it will look once this nibble is written.
  always_comb begin
    nibA     = a_q[{nibIdx_q, 2'b00} +: 4];
    nibB     = ~b_q[{nibIdx_q, 2'b00} +: 4];
    carryIn  = ~borrowChain_q;
    gen      = nibA & nibB;
    prop     = nibA ^ nibB;
    carry[0] = carryIn;
    carry[1] = gen[0] | (prop[0] & carryIn);
    carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & carryIn);
    carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
             | (prop[2] & prop[1] & prop[0] & carryIn);
    carryOut = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
             | (prop[3] & prop[2] & prop[1] & gen[0])
             | (prop[3] & prop[2] & prop[1] & prop[0] & carryIn);
    nibSum   = prop ^ carry;
    borrowChain_d = ~carryOut;
    diff_d   = diff_q;
    diff_d[{nibIdx_q, 2'b00} +: 4] = nibSum;
  end

  // Control FSM with registered status, datapath and flag outputs. Start is
  // only honoured in IDLE/DONE so a second request during RUN is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      nibIdx_q      <= '0;
      borrowChain_q <= 1'b0;
      diff_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      borrowOut_q   <= 1'b0;
      zero_q        <= 1'b0;
      neg_q         <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state_q       <= RUN;
            a_q           <= bus.a;
            b_q           <= bus.b;
            nibIdx_q      <= '0;
            borrowChain_q <= 1'b0;
            diff_q        <= '0;
            busy_q        <= 1'b1;
            borrowOut_q   <= 1'b0;
            zero_q        <= 1'b0;
            neg_q         <= 1'b0;
            ovf_q         <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          diff_q        <= diff_d;
          borrowChain_q <= borrowChain_d;
          if (nibIdx_q == LAST_IDX) begin
            state_q     <= DONE;
            nibIdx_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            borrowOut_q <= borrowChain_d;
            zero_q      <= (diff_d == '0);
            neg_q       <= diff_d[WIDTH-1];
            ovf_q       <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                           (diff_d[WIDTH-1] != a_q[WIDTH-1]);
          end else begin
            nibIdx_q <= nibIdx_q + IDXW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrowOut_q;
  assign bus.zero       = zero_q;
  assign bus.neg        = neg_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor (WIDTH=32).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_nibble_serial_subtractor;

  logic clk;
  logic rst;
  int   testCount;
  int   failCount;

  nibble_serial_subtractor_if #(.WIDTH(32)) bus ();

  nibble_serial_subtractor #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        neg;
    logic        ovf;
  } vector_t;

  vector_t vectors[6];

  // Compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents operands with start for one cycle; returns at the falling edge
  // just after the accepting rising edge.
  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB);
    bus.a     = opA;
    bus.b     = opB;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts busy cycles until done is seen, bounded to avoid hanging.
  task automatic waitDone(output int busyCnt, output bit seen);
    busyCnt = 0;
    seen    = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busyCnt++;
      @(negedge clk);
    end
  endtask

  task automatic checkResult(input string tag, input vector_t v);
    checkOutput($sformatf("%s diff", tag), bus.diff, v.diff);
    checkOutput($sformatf("%s borrow", tag), 32'(bus.borrow_out), 32'(v.borrow));
    checkOutput($sformatf("%s zero", tag), 32'(bus.zero), 32'(v.zero));
    checkOutput($sformatf("%s neg", tag), 32'(bus.neg), 32'(v.neg));
    checkOutput($sformatf("%s ovf", tag), 32'(bus.ovf), 32'(v.ovf));
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput($sformatf("%s busy", tag), 32'(bus.busy), 32'd0);
    checkOutput($sformatf("%s done", tag), 32'(bus.done), 32'd0);
    checkOutput($sformatf("%s diff", tag), bus.diff, 32'd0);
    checkOutput($sformatf("%s borrow", tag), 32'(bus.borrow_out), 32'd0);
    checkOutput($sformatf("%s zero", tag), 32'(bus.zero), 32'd0);
    checkOutput($sformatf("%s neg", tag), 32'(bus.neg), 32'd0);
    checkOutput($sformatf("%s ovf", tag), 32'(bus.ovf), 32'd0);
  endtask

  initial begin
    int      busyCnt;
    bit      seen;
    bit      lateDone;
    vector_t v;

    testCount = 0;
    failCount = 0;

    vectors[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0};
    vectors[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0};
    vectors[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vectors[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
    vectors[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vectors[5] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #12;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors: latency, single-cycle done, result and flags, hold.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vectors[i].a, vectors[i].b);
      waitDone(busyCnt, seen);
      checkOutput($sformatf("v%0d busyCycles", i), 32'(busyCnt), 32'd8);
      checkOutput($sformatf("v%0d doneSeen", i), 32'(seen), 32'd1);
      checkResult($sformatf("v%0d", i), vectors[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d doneOneCycle", i), 32'(bus.done), 32'd0);
      checkOutput($sformatf("v%0d diffHeld", i), bus.diff, vectors[i].diff);
    end

    // Start re-pulsed with other operands during RUN must be ignored.
    applyStimulus(32'h0000_0005, 32'h0000_0003);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'hAAAA_AAAA;
    bus.b     = 32'h0000_0001;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(busyCnt, seen);
    checkOutput("ignoreStart busyCycles", 32'(busyCnt), 32'd5);
    checkOutput("ignoreStart doneSeen", 32'(seen), 32'd1);
    checkResult("ignoreStart", vectors[0]);
    @(negedge clk);
    checkOutput("ignoreStart noRestart", 32'(bus.busy), 32'd0);

    // Start held during the done cycle launches the next op without a bubble.
    applyStimulus(32'h0000_0005, 32'h0000_0003);
    waitDone(busyCnt, seen);
    checkOutput("b2b first doneSeen", 32'(seen), 32'd1);
    checkOutput("b2b first diff", bus.diff, 32'h0000_0002);
    applyStimulus(32'h0000_0003, 32'h0000_0005);
    checkOutput("b2b busyNext", 32'(bus.busy), 32'd1);
    checkOutput("b2b doneDropped", 32'(bus.done), 32'd0);
    checkOutput("b2b diffCleared", bus.diff, 32'd0);
    waitDone(busyCnt, seen);
    checkOutput("b2b second busyCycles", 32'(busyCnt), 32'd8);
    checkOutput("b2b second doneSeen", 32'(seen), 32'd1);
    checkResult("b2b second", vectors[1]);
    @(negedge clk);

    // Asynchronous reset in the middle of RUN aborts without a done pulse.
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0000);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort partialDiff", bus.diff, 32'h0000_0FFF);
    checkOutput("abort busyBefore", 32'(bus.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("abort");
    @(negedge clk);
    rst = 1'b0;
    lateDone = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) lateDone = 1'b1;
    end
    checkOutput("abort noDoneAfter", 32'(lateDone), 32'd0);

    // Fresh operation after reset runs at normal latency.
    v = '{32'h0000_0009, 32'h0000_0004, 32'h0000_0005, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(v.a, v.b);
    waitDone(busyCnt, seen);
    checkOutput("postReset busyCycles", 32'(busyCnt), 32'd8);
    checkOutput("postReset doneSeen", 32'(seen), 32'd1);
    checkResult("postReset", v);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
Name: nibble_serial_subtractor

Overview:
- Multi-cycle WIDTH-bit subtractor/comparator for the miniRISC ALU path.
- Processes one 4-bit nibble per clock using borrow-lookahead logic, LSB nibble first; the registered borrow chains between nibbles.
- Start/busy/done handshake; produces the difference plus borrow, zero, negative and signed-overflow flags for SUB/CMP and branch-compare instructions.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 4 and at least 4.
- NNIB, WIDTH/4, derived nibble count; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled on a rising edge while the block is idle-accepting.
- a  input  WIDTH  minuend; sampled with the accepted start.
- b  input  WIDTH  subtrahend; sampled with the accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  1 iff a < b (unsigned).
- zero  output  1  1 iff diff == 0.
- neg  output  1  diff[WIDTH-1].
- ovf  output  1  signed overflow of a - b.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - busy, done, diff, borrow_out, zero, neg and ovf are all 0.
  - Internal operand registers, nibble index and borrow register are cleared.
- States:
  - IDLE: done=0, busy=0.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, busy=0.
- Idle-accepting means IDLE or DONE.
- IDLE/DONE -> RUN on start=1:
  - Latch a and b.
  - Nibble index = 0, borrow register = 0.
- RUN, each cycle at nibble i:
  - Compute a[4i+3:4i] + ~b[4i+3:4i] + ~borrow with generate/propagate lookahead.
  - borrow_next = ~carry_out of that nibble.
  - Write the result nibble into diff[4i+3:4i] (diff is cleared on start acceptance).
  - Increment i.
- RUN -> DONE after the edge that processes nibble NNIB-1.
- On that same edge, register the flags from the full result:
  - borrow_out = final borrow.
  - zero = (diff == 0).
  - neg = diff MSB.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), using latched operands.
- DONE -> IDLE on the next edge when start=0; DONE -> RUN when start=1 (back-to-back, no bubble).
- Latency: start accepted at edge k; busy=1 during cycles k+1 .. k+NNIB; done=1 during cycle k+NNIB+1.
  - WIDTH=32: 8 busy cycles, done in the 9th cycle after the accepting edge.
- Output hold and visibility:
  - diff and flags hold their values after done until the next accepted start.
  - diff is cleared on acceptance and is partially updated during RUN; only the value at done is architecturally valid.
  - Flags are cleared on acceptance and update only at completion.
- start while busy=1: ignored; operands and progress are unaffected; no queuing.
- a/b changes while busy: no effect (operands latched).
- Reset asserted mid-RUN: immediate abort to the reset values above; no done pulse is generated for the aborted operation.
- Borrow never leaks between operations (it is cleared on acceptance).
- Arithmetic is purely modulo 2^WIDTH; no saturation.

Test Plan:
- a=5, b=3 (WIDTH=32), start pulsed 1 cycle -> busy high 8 cycles, then done=1 for exactly 1 cycle; diff=0x00000002, borrow_out=0, zero=0, neg=0, ovf=0.
- a=3, b=5 -> diff=0xFFFFFFFE, borrow_out=1, neg=1, zero=0, ovf=0.
- Signed overflow:
  - a=0x80000000, b=0x00000001 -> diff=0x7FFFFFFF, ovf=1, neg=0, borrow_out=0.
  - a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow_out=1.
- Equal operands and borrow chain:
  - a=b=0x12345678 -> diff=0, zero=1, borrow_out=0.
  - a=0x00010000, b=0x00000001 -> diff=0x0000FFFF (borrow ripples across 4 nibbles).
- Handshake:
  - start re-pulsed with different operands on cycle 3 of RUN -> ignored; result matches the original operands.
  - start held high during the done cycle -> new operation begins immediately; busy=1 on the next cycle.
- Reset:
  - rst asserted in cycle 4 of RUN -> all outputs 0 immediately (async); no done follows.
  - After reset release, a fresh start with a=9, b=4 -> diff=5 at normal latency.
